// File: rtl/iir_out_buffer.sv
// -----------------------------------------------------------------------------
// iir_out_buffer
//   Output stage for the 4-section IIR filter. It takes the filter's
//   non-stallable 24-bit sample stream and rounds each sample down to OUT_W
//   bits (round-half-up, with saturation). The results go into a
//   first-word-fall-through FIFO, which a consumer drains with valid/ready.
//   Overflow and saturation statistics are exposed for the trace bench.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : synchronous reset, active-high
//   data_in        : signed DATA_W-bit sample from the filter
//   data_valid_in  : sample strobe, one sample per high cycle, no backpressure
//   data_out       : signed OUT_W-bit FIFO head sample (0 while empty)
//   data_valid_out : FIFO non-empty
//   data_ready_in  : consumer accepts the head sample this cycle
//   level          : FIFO occupancy, 0..DEPTH
//   overflow       : sticky, a sample was dropped because the FIFO was full
//   sat_cnt        : number of saturated samples, holds at 16'hFFFF
//   clr_flags      : clears overflow and sat_cnt (a same-cycle event wins)
// -----------------------------------------------------------------------------
module iir_out_buffer #(
   parameter  int DATA_W = 24,
   parameter  int OUT_W  = 16,
   parameter  int DEPTH  = 16,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid_in,
   output logic [OUT_W-1:0]  data_out,
   output logic              data_valid_out,
   input  logic              data_ready_in,
   output logic [AW:0]       level,
   output logic              overflow,
   output logic [15:0]       sat_cnt,
   input  logic              clr_flags
);

   localparam int S = DATA_W - OUT_W;

   // The rounding and the range checks use one extra sign bit, so that
   // the most positive input rounds up past the limit and saturates
   // instead of wrapping.
   localparam logic signed [DATA_W:0] RND   = (DATA_W+1)'(1) << (S - 1);
   localparam logic signed [DATA_W:0] Q_MAX = (DATA_W+1)'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [DATA_W:0] Q_MIN = ~Q_MAX;
   localparam logic [OUT_W-1:0]       O_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]       O_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [AW:0]            DEPTH_L = (AW+1)'(DEPTH);

   // ---------------------------------------------------------------------------
   // Conversion stage
   // ---------------------------------------------------------------------------
   logic signed [DATA_W:0] t_ext;
   logic signed [DATA_W:0] q_full;

   logic [OUT_W-1:0] conv_data_d,  conv_data_q;
   logic             conv_sat_d,   conv_sat_q;
   logic             conv_valid_d, conv_valid_q;

   always_comb begin
      t_ext        = $signed({data_in[DATA_W-1], data_in}) + RND;
      q_full       = t_ext >>> S;
      conv_sat_d   = 1'b0;
      conv_data_d  = q_full[OUT_W-1:0];
      if (q_full > Q_MAX) begin
         conv_data_d = O_MAX;
         conv_sat_d  = 1'b1;
      end else if (q_full < Q_MIN) begin
         conv_data_d = O_MIN;
         conv_sat_d  = 1'b1;
      end
      conv_valid_d = data_valid_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         conv_valid_q <= 1'b0;
         conv_sat_q   <= 1'b0;
         conv_data_q  <= '0;
      end else begin
         conv_valid_q <= conv_valid_d;
         conv_sat_q   <= conv_sat_d;
         conv_data_q  <= conv_data_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO (first-word-fall-through)
   // ---------------------------------------------------------------------------
   logic [OUT_W-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_d, wr_ptr_q;
   logic [AW:0]      rd_ptr_d, rd_ptr_q;
   logic [AW:0]      level_w;
   logic             empty, full;
   logic             push, pop, drop;

   always_comb begin
      level_w  = wr_ptr_q - rd_ptr_q;
      empty    = (level_w == '0);
      full     = (level_w == DEPTH_L);
      pop      = !empty && data_ready_in;
      // When the FIFO is full, a pop in the same cycle frees the slot the
      // write lands in. The write slot equals the read slot at that point,
      // and the old head has already been consumed through data_out.
      push     = conv_valid_q && (!full || pop);
      drop     = conv_valid_q && full && !pop;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: data_out is forced to zero while the FIFO is
   // empty.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= conv_data_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Statistics
   // ---------------------------------------------------------------------------
   logic        overflow_d, overflow_q;
   logic [15:0] sat_cnt_d,  sat_cnt_q;

   always_comb begin
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_flags) begin
         overflow_d = 1'b0;
      end

      // Dropped samples are counted too. A clear in the same cycle as a
      // saturation event restarts the count at one.
      sat_cnt_d = sat_cnt_q;
      if (conv_valid_q && conv_sat_q) begin
         if (clr_flags) begin
            sat_cnt_d = 16'd1;
         end else if (sat_cnt_q != '1) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
         end
      end else if (clr_flags) begin
         sat_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
         sat_cnt_q  <= '0;
      end else begin
         overflow_q <= overflow_d;
         sat_cnt_q  <= sat_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      data_valid_out = !empty;
      data_out       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
      level          = level_w;
      overflow       = overflow_q;
      sat_cnt        = sat_cnt_q;
   end

endmodule

// File: tb/tb_iir_out_buffer.sv
module tb_iir_out_buffer;

   localparam int DATA_W = 24;
   localparam int OUT_W  = 16;
   localparam int DEPTH  = 16;
   localparam int AW     = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] data_in = '0;
   logic              data_valid_in = 1'b0;
   logic [OUT_W-1:0]  data_out;
   logic              data_valid_out;
   logic              data_ready_in = 1'b0;
   logic [AW:0]       level;
   logic              overflow;
   logic [15:0]       sat_cnt;
   logic              clr_flags = 1'b0;

   iir_out_buffer #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .data_valid_in  (data_valid_in),
      .data_out       (data_out),
      .data_valid_out (data_valid_out),
      .data_ready_in  (data_ready_in),
      .level          (level),
      .overflow       (overflow),
      .sat_cnt        (sat_cnt),
      .clr_flags      (clr_flags)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a queue of sample values, a one-deep pending
   // conversion, and the two statistics.
   int q_m[$];
   bit ovf_m;
   int sat_m;
   bit pend_v;
   int pend_q;
   bit pend_s;

   // Round half up: floor((x + 128) / 256), then clamp to 16-bit signed.
   task automatic convert(input logic [DATA_W-1:0] x, output int q, output bit s);
      int v;
      v = $signed(x);
      q = (v + 128) >>> 8;
      s = 1'b0;
      if (q > 32767) begin
         q = 32767;
         s = 1'b1;
      end else if (q < -32768) begin
         q = -32768;
         s = 1'b1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [15:0] e16;
      e16 = (q_m.size() != 0) ? 16'(q_m[0]) : 16'h0;
      chk("valid",    32'(data_valid_out), 32'(q_m.size() != 0));
      chk("data_out", 32'(data_out),       32'(e16));
      chk("level",    32'(level),          32'(q_m.size()));
      chk("overflow", 32'(overflow),       32'(ovf_m));
      chk("sat_cnt",  32'(sat_cnt),        32'(sat_m));
   endtask

   task automatic model(input logic [DATA_W-1:0] d, input logic v, input logic r, input logic c);
      bit pop;
      bit ovf_ev;
      bit sat_ev;
      pop    = (q_m.size() != 0) && r;
      ovf_ev = 1'b0;
      sat_ev = pend_v && pend_s;
      if (pop) void'(q_m.pop_front());
      if (pend_v) begin
         if (q_m.size() < DEPTH) q_m.push_back(pend_q);
         else                    ovf_ev = 1'b1;
      end
      if (ovf_ev)  ovf_m = 1'b1;
      else if (c)  ovf_m = 1'b0;
      if (sat_ev) sat_m = c ? 1 : ((sat_m < 65535) ? sat_m + 1 : 65535);
      else if (c) sat_m = 0;
      pend_v = v;
      if (v) convert(d, pend_q, pend_s);
   endtask

   task automatic step(input logic [DATA_W-1:0] d, input logic v, input logic r, input logic c);
      data_in       = d;
      data_valid_in = v;
      data_ready_in = r;
      clr_flags     = c;
      @(posedge clk);
      model(d, v, r, c);
      #1 compare_all();
   endtask

   task automatic do_reset(input logic [DATA_W-1:0] d, input logic v);
      rst           = 1'b1;
      data_in       = d;
      data_valid_in = v;
      data_ready_in = 1'b0;
      clr_flags     = 1'b0;
      @(posedge clk);
      q_m.delete();
      ovf_m  = 1'b0;
      sat_m  = 0;
      pend_v = 1'b0;
      #1 compare_all();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] rnd;

      // Reset, applied twice so the state is fully defined.
      do_reset('0, 1'b0);
      do_reset('0, 1'b0);

      // 1 Rounding: the first valid output appears 2 edges after the first push
      step(24'h000180, 1'b1, 1'b1, 1'b0);
      chk("t1_not_yet", 32'(data_valid_out), 32'd0);
      step(24'hFFFE80, 1'b1, 1'b1, 1'b0);
      chk("t1_first", 32'(data_out), 32'h0002);
      step('0, 1'b0, 1'b1, 1'b0);
      chk("t1_second", 32'(data_out), 32'hFFFF);
      chk("t1_sat", 32'(sat_cnt), 32'd0);

      // 2 Saturation edges
      step(24'h7FFFFF, 1'b1, 1'b1, 1'b0);
      step(24'h800000, 1'b1, 1'b1, 1'b0);
      chk("t2_pos", 32'(data_out), 32'h7FFF);
      chk("t2_sat1", 32'(sat_cnt), 32'd1);
      step(24'h7FFF7F, 1'b1, 1'b1, 1'b0);
      chk("t2_neg", 32'(data_out), 32'h8000);
      step('0, 1'b0, 1'b1, 1'b0);
      chk("t2_near", 32'(data_out), 32'h7FFF);
      chk("t2_sat_hold", 32'(sat_cnt), 32'd1);
      step('0, 1'b0, 1'b1, 1'b0);

      // 3 Overflow: 20 pushes with ready low, then drain
      for (int i = 1; i <= 20; i++) step(24'(i * 256), 1'b1, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0, 1'b0);
      chk("t3_level", 32'(level), 32'd16);
      chk("t3_ovf", 32'(overflow), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         chk("t3_order", 32'(data_out), 32'(i));
         step('0, 1'b0, 1'b1, 1'b0);
      end
      chk("t3_empty", 32'(data_valid_out), 32'd0);
      step('0, 1'b0, 1'b0, 1'b1);

      // 4 Full+pop in the same cycle
      for (int i = 1; i <= 16; i++) step(24'(i * 256), 1'b1, 1'b0, 1'b0);
      step(24'h006400, 1'b1, 1'b0, 1'b0);
      step('0, 1'b0, 1'b1, 1'b0);
      chk("t4_level", 32'(level), 32'd16);
      chk("t4_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 15; i++) step('0, 1'b0, 1'b1, 1'b0);
      chk("t4_last", 32'(data_out), 32'h0064);
      step('0, 1'b0, 1'b1, 1'b0);

      // 5 Flag clear race with a saturation event
      step(24'h7FFFFF, 1'b1, 1'b1, 1'b0);
      step('0, 1'b0, 1'b1, 1'b1);
      chk("t5_race", 32'(sat_cnt), 32'd1);
      step('0, 1'b0, 1'b1, 1'b1);
      chk("t5_clr", 32'(sat_cnt), 32'd0);
      chk("t5_clr_ovf", 32'(overflow), 32'd0);

      // 6 Reset mid-stream: 8 samples queued plus one in conversion
      for (int i = 1; i <= 9; i++) step(24'(i * 256), 1'b1, 1'b0, 1'b0);
      do_reset(24'h000A00, 1'b1);
      chk("t6_level", 32'(level), 32'd0);
      chk("t6_valid", 32'(data_valid_out), 32'd0);
      chk("t6_data", 32'(data_out), 32'd0);
      step('0, 1'b0, 1'b1, 1'b0);
      step('0, 1'b0, 1'b1, 1'b0);
      chk("t6_no_ghost", 32'(data_valid_out), 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 2500; n++) begin
         rnd = $urandom;
         if ($urandom_range(0, 299) == 0) begin
            do_reset(rnd[23:0], 1'b1);
         end else begin
            if (rnd[31:30] == 2'b00) rnd[23:0] = 24'($signed(rnd[15:0]));
            step(rnd[23:0], ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 39) == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
